// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolver with 2-bit BHT, registered redirect and multi-cycle front-end flush.
// Latency: redirect/flush one cycle after a mispredict; BHT lookup is combinational. Optional BR_PERF_CNT_EN adds perf counters.
// Backpressure: none; EX instructions arriving while flushing are treated as wrong-path and dropped.
module branch_resolve_ctrl #(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_ex_i,
    input  logic        is_jal_i,
    input  logic        is_jalr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] pc_ex_i,
    input  logic [31:0] target_i,
    input  logic        pred_taken_ex_i,
    input  logic        BrEq_i,
    input  logic        BrLt_i,
    output logic        BrUn_o,
    input  logic [31:0] pc_if_i,
    output logic        pred_taken_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        illegal_br_o
`ifdef BR_PERF_CNT_EN
    ,
    output logic [31:0] br_cnt_o,
    output logic [31:0] mispred_cnt_o
`endif
);
    localparam int IW = $clog2(BHT_ENTRIES);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t          state;
    logic [CW-1:0]   flush_cnt;
    logic [1:0]      bht [BHT_ENTRIES];

    logic            taken;
    logic            legal;
    logic            cond;
    logic            accept;
    logic            eff_pred;
    logic            mispredict;
    logic            bht_upd;
    logic [IW-1:0]   ex_idx;
    logic [IW-1:0]   if_idx;
    logic [1:0]      ctr;
    logic [1:0]      ctr_next;

    wire unused_pc_bits = ^{pc_if_i[31:IW+2], pc_if_i[1:0]};

    assign BrUn_o = (funct3_i == 3'b110) || (funct3_i == 3'b111);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (funct3_i)
            3'b000:          taken = BrEq_i;
            3'b001:          taken = ~BrEq_i;
            3'b100, 3'b110:  taken = BrLt_i;
            3'b101, 3'b111:  taken = ~BrLt_i;
            default: begin
                taken = 1'b0;
                legal = 1'b0;
            end
        endcase
        // Jumps ignore funct3 entirely.
        if (is_jal_i || is_jalr_i) begin
            taken = 1'b1;
            legal = 1'b1;
        end
    end

    assign cond       = !is_jal_i && !is_jalr_i;
    assign accept     = valid_ex_i && (state == IDLE);
    // No target prediction exists, so a taken JALR must always redirect.
    assign eff_pred   = is_jalr_i ? 1'b0 : pred_taken_ex_i;
    assign mispredict = accept && (taken != eff_pred);
    assign bht_upd    = accept && cond && legal;

    assign ex_idx = pc_ex_i[IW+1:2];
    assign if_idx = pc_if_i[IW+1:2];
    assign ctr    = bht[ex_idx];

    always_comb begin
        ctr_next = ctr;
        if (taken && ctr != 2'b11)
            ctr_next = ctr + 2'b01;
        else if (!taken && ctr != 2'b00)
            ctr_next = ctr - 2'b01;
    end

    assign pred_taken_o = bht[if_idx][1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            flush_cnt     <= '0;
            flush_o       <= 1'b0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= 32'd0;
            illegal_br_o  <= 1'b0;
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= 2'b01;
        end else begin
            illegal_br_o <= accept && cond && !legal;
            redirect_o   <= mispredict;
            if (mispredict)
                redirect_pc_o <= taken ? target_i : pc_ex_i + 32'd4;
            if (bht_upd)
                bht[ex_idx] <= ctr_next;
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        state     <= FLUSH;
                        flush_o   <= 1'b1;
                        flush_cnt <= CW'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state   <= IDLE;
                        flush_o <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BR_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_cnt_o      <= 32'd0;
            mispred_cnt_o <= 32'd0;
        end else begin
            if (bht_upd)
                br_cnt_o <= br_cnt_o + 32'd1;
            if (mispredict)
                mispred_cnt_o <= mispred_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: redirect, flush timing, BHT training and wrong-path drop.
module tb_branch_resolve_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_ex_i;
    logic        is_jal_i;
    logic        is_jalr_i;
    logic [2:0]  funct3_i;
    logic [31:0] pc_ex_i;
    logic [31:0] target_i;
    logic        pred_taken_ex_i;
    logic        BrEq_i;
    logic        BrLt_i;
    logic        BrUn_o;
    logic [31:0] pc_if_i;
    logic        pred_taken_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        illegal_br_o;
`ifdef BR_PERF_CNT_EN
    logic [31:0] br_cnt_o;
    logic [31:0] mispred_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    branch_resolve_ctrl #(.BHT_ENTRIES(16), .FLUSH_CYCLES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_ex_i(valid_ex_i),
        .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i), .funct3_i(funct3_i),
        .pc_ex_i(pc_ex_i), .target_i(target_i), .pred_taken_ex_i(pred_taken_ex_i),
        .BrEq_i(BrEq_i), .BrLt_i(BrLt_i), .BrUn_o(BrUn_o), .pc_if_i(pc_if_i),
        .pred_taken_o(pred_taken_o), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o), .flush_o(flush_o), .illegal_br_o(illegal_br_o)
`ifdef BR_PERF_CNT_EN
        , .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_br(input logic jal, input logic jalr, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pred, input logic eq, input logic lt);
        valid_ex_i      = 1'b1;
        is_jal_i        = jal;
        is_jalr_i       = jalr;
        funct3_i        = f3;
        pc_ex_i         = pc;
        target_i        = tgt;
        pred_taken_ex_i = pred;
        BrEq_i          = eq;
        BrLt_i          = lt;
    endtask

    task automatic peek_pred(input string tag, input logic [31:0] pc, input logic exp);
        pc_if_i = pc;
        #1;
        check(tag, {31'd0, pred_taken_o}, {31'd0, exp});
    endtask

    initial begin
        rst_i = 1'b1; valid_ex_i = 1'b0; is_jal_i = 1'b0; is_jalr_i = 1'b0;
        funct3_i = 3'b000; pc_ex_i = 32'd0; target_i = 32'd0; pred_taken_ex_i = 1'b0;
        BrEq_i = 1'b0; BrLt_i = 1'b0; pc_if_i = 32'd0;
        tick(); tick();
        rst_i = 1'b0;

        // Reset state
        check("rst_redirect", {31'd0, redirect_o}, 32'd0);
        check("rst_redirect_pc", redirect_pc_o, 32'd0);
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        check("rst_illegal", {31'd0, illegal_br_o}, 32'd0);
        check("rst_brun", {31'd0, BrUn_o}, 32'd0);
        peek_pred("rst_pred_0", 32'h0, 1'b0);
        peek_pred("rst_pred_3c", 32'h3C, 1'b0);
`ifdef BR_PERF_CNT_EN
        check("rst_br_cnt", br_cnt_o, 32'd0);
        check("rst_mis_cnt", mispred_cnt_o, 32'd0);
`endif

        // BEQ taken, predicted not-taken
        set_br(1'b0, 1'b0, 3'b000, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0);
        peek_pred("beq_pred_before", 32'h100, 1'b0);
        tick();
        valid_ex_i = 1'b0;
        check("beq_redirect", {31'd0, redirect_o}, 32'd1);
        check("beq_redirect_pc", redirect_pc_o, 32'h140);
        check("beq_flush1", {31'd0, flush_o}, 32'd1);
        peek_pred("beq_bht_10", 32'h100, 1'b1);
        tick();
        check("beq_redirect_pulse", {31'd0, redirect_o}, 32'd0);
        check("beq_flush2", {31'd0, flush_o}, 32'd1);
        check("beq_pc_hold", redirect_pc_o, 32'h140);
        tick();
        check("beq_flush_end", {31'd0, flush_o}, 32'd0);

        // BLTU not-taken, predicted taken; then a wrong-path mispredict during flush
        set_br(1'b0, 1'b0, 3'b110, 32'h200, 32'h300, 1'b1, 1'b0, 1'b0);
        #1;
        check("bltu_brun", {31'd0, BrUn_o}, 32'd1);
        tick();
        check("bltu_redirect", {31'd0, redirect_o}, 32'd1);
        check("bltu_redirect_pc", redirect_pc_o, 32'h204);
        set_br(1'b0, 1'b0, 3'b000, 32'h10, 32'h500, 1'b0, 1'b1, 1'b0);
        tick();
        valid_ex_i = 1'b0;
        check("wrongpath_no_redirect", {31'd0, redirect_o}, 32'd0);
        check("wrongpath_pc_hold", redirect_pc_o, 32'h204);
        check("wrongpath_flush", {31'd0, flush_o}, 32'd1);
        tick();
        check("wrongpath_flush_end", {31'd0, flush_o}, 32'd0);
        check("wrongpath_no_late_redirect", {31'd0, redirect_o}, 32'd0);
        peek_pred("wrongpath_bht_untouched", 32'h10, 1'b0);
        peek_pred("bltu_bht_01", 32'h100, 1'b0);

        funct3_i = 3'b111; #1;
        check("bgeu_brun", {31'd0, BrUn_o}, 32'd1);
        funct3_i = 3'b101; #1;
        check("bge_brun", {31'd0, BrUn_o}, 32'd0);

        // Three taken BNE train idx 2 to strongly taken, then two not-taken
        set_br(1'b0, 1'b0, 3'b001, 32'h8, 32'h40, 1'b1, 1'b0, 1'b0);
        peek_pred("bne_no_bypass", 32'h8, 1'b0);
        tick(); tick(); tick();
        check("bne_no_redirect", {31'd0, redirect_o}, 32'd0);
        peek_pred("bne_pred_8", 32'h8, 1'b1);
        peek_pred("bne_pred_48", 32'h48, 1'b1);
        BrEq_i = 1'b1; pred_taken_ex_i = 1'b0;
        tick();
        peek_pred("bne_sat_10", 32'h8, 1'b1);
        tick();
        valid_ex_i = 1'b0;
        peek_pred("bne_down_01", 32'h8, 1'b0);
        check("bne_nt_no_flush", {31'd0, flush_o}, 32'd0);

        // JALR predicted taken still redirects; funct3 is ignored
        set_br(1'b0, 1'b1, 3'b010, 32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b0, 1'b0);
        tick();
        valid_ex_i = 1'b0;
        check("jalr_redirect", {31'd0, redirect_o}, 32'd1);
        check("jalr_redirect_pc", redirect_pc_o, 32'h1234);
        check("jalr_no_illegal", {31'd0, illegal_br_o}, 32'd0);
        tick(); tick();
        check("jalr_flush_end", {31'd0, flush_o}, 32'd0);
        peek_pred("jalr_no_bht", 32'hFFFF_FFFC, 1'b0);

        // Illegal funct3 resolves not-taken; fall-through wraps to 0
        set_br(1'b0, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b1, 1'b1);
        tick();
        valid_ex_i = 1'b0;
        check("ill_pulse", {31'd0, illegal_br_o}, 32'd1);
        check("ill_redirect", {31'd0, redirect_o}, 32'd1);
        check("ill_redirect_pc_wrap", redirect_pc_o, 32'h0);
        tick();
        check("ill_pulse_end", {31'd0, illegal_br_o}, 32'd0);
        tick();
        check("ill_flush_end", {31'd0, flush_o}, 32'd0);
        peek_pred("ill_no_bht", 32'hFFFF_FFFC, 1'b0);
`ifdef BR_PERF_CNT_EN
        check("br_cnt_total", br_cnt_o, 32'd7);
        check("mis_cnt_total", mispred_cnt_o, 32'd4);
`endif

        // Reset in the middle of a flush
        set_br(1'b0, 1'b0, 3'b000, 32'h8, 32'h80, 1'b0, 1'b1, 1'b0);
        tick();
        valid_ex_i = 1'b0;
        check("midrst_flush_on", {31'd0, flush_o}, 32'd1);
        peek_pred("midrst_bht_trained", 32'h8, 1'b1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrst_flush_off", {31'd0, flush_o}, 32'd0);
        check("midrst_redirect_off", {31'd0, redirect_o}, 32'd0);
        check("midrst_redirect_pc", redirect_pc_o, 32'd0);
        peek_pred("midrst_bht_reinit", 32'h8, 1'b0);
`ifdef BR_PERF_CNT_EN
        check("midrst_br_cnt", br_cnt_o, 32'd0);
        check("midrst_mis_cnt", mispred_cnt_o, 32'd0);
`endif
        tick();
        check("midrst_stays_idle", {31'd0, flush_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
